quickq_sorted_ctrl: RTL and testbench
=====================================

Name: quickq_sorted_ctrl

Overview:
- Parametrised controller for the QuickQ priority queue. It keeps up to DEPTH entries in key order inside a 1R1W synchronous RAM.
- Enqueue does an insertion-sort walk: compare the held value against each entry, swap where it wins, and write the final held value at the tail.
- Dequeue pops the head and shifts the remaining entries down by one.
- Sits between the router-side producer/consumer and the QuickQ storage. Adds ready/valid handshakes, flush, ordering mode and occupancy reporting.

Parameters:
- DATA_W, 32, entry width in bits.
- KEY_W, 16, key field width; key = entry[DATA_W-1 -: KEY_W].
- DEPTH, 16, maximum number of entries; must be ≥2.
- MIN_FIRST, 1, 1 = smallest key dequeued first, 0 = largest key dequeued first.
- CNT_W, $clog2(DEPTH+1), width of the count output.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- enq_valid  in  1  enqueue request.
- enq_data  in  DATA_W  entry to insert.
- enq_ready  out  1  enqueue accepted when enq_valid && enq_ready.
- deq_req  in  1  dequeue request.
- deq_ready  out  1  dequeue accepted when deq_req && deq_ready.
- deq_valid  out  1  one-cycle pulse; deq_data is valid in that cycle.
- deq_data  out  DATA_W  popped head entry.
- enq_done  out  1  one-cycle pulse when the insertion completes.
- count  out  CNT_W  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, count = 0, internal idx/hold = 0.
  - Outputs: enq_done = 0, deq_valid = 0, deq_data = 0, empty = 1, full = 0, busy = 0.
  - RAM contents are don't-care.
- Ready logic:
  - enq_ready = IDLE && !full && !flush.
  - deq_ready = IDLE && !empty && !flush && !(enq_valid && enq_ready). Enqueue wins over a same-cycle dequeue.
- "precedes(a,b)" means key(a) < key(b) when MIN_FIRST = 1, and key(a) > key(b) otherwise. The comparison is strict, so equal keys keep insertion order (stable).
- States (enum in package): IDLE, ENQ_READ, ENQ_CMP, ENQ_WRITE, DEQ_READ0, DEQ_OUT, DEQ_READ, DEQ_SHIFT.
- Enqueue, accepted in IDLE:
  - On accept: hold <= enq_data, idx <= 0. Go to ENQ_WRITE if count == 0, else ENQ_READ.
  - ENQ_READ: rd_addr = idx, then ENQ_CMP.
  - ENQ_CMP: if precedes(hold, rd_data), write hold to idx and set hold <= rd_data. Then idx <= idx+1. Go to ENQ_WRITE if idx+1 == count, else ENQ_READ.
  - ENQ_WRITE: write hold to idx, count <= count+1, enq_done = 1, then IDLE.
  - Latency: accepted in cycle T with n entries stored → enq_done in T+2n+1, enq_ready high again in T+2n+2.
- Dequeue, accepted in IDLE:
  - DEQ_READ0: read address 0.
  - DEQ_OUT: deq_valid = 1, deq_data <= rd_data (registered, held until the next pop). If count == 1: count <= 0 and go to IDLE. Else idx <= 1 and go to DEQ_READ.
  - DEQ_READ: read idx.
  - DEQ_SHIFT: write rd_data to idx-1, then idx <= idx+1. If idx+1 == count: count <= count-1 and go to IDLE. Else DEQ_READ.
  - Latency: accepted in T → deq_valid in T+2, deq_ready high again in T+2n+1.
- Flush:
  - Taken in any state.
  - Next cycle: count = 0, state = IDLE, no enq_done or deq_valid pulse.
  - An in-flight operation is abandoned.
  - Flush has priority over acceptance.
- RAM usage:
  - The FSM never reads and writes the same address in one cycle.
  - RAM read-during-write to the same address returns old data.
- Outputs not listed above hold their values outside their defining states. Every comb path has full defaults, so no latches.

Decomposition:
- quickq_pkg:
  - qq_state_t enum.
  - Function precedes(a, b, min_first), parametrised by KEY_W through the caller's slice.
- Sub-module quickq_ram:
  - DEPTH × DATA_W, one synchronous read port (1-cycle latency) and one write port.
  - No reset on the array.

Test Plan:
- Reset: hold rst low mid-enqueue (count = 2) → count = 0, empty = 1, busy = 0, enq_ready = 1 one cycle after release.
- Stable ordering: DATA_W = 16, KEY_W = 8, DEPTH = 4, MIN_FIRST = 1. Enqueue 0x0501, 0x0202, 0x0903, 0x0204, then dequeue ×4 → deq_data 0x0202, 0x0204, 0x0501, 0x0903, then empty = 1.
- Full: after the 4 enqueues above, full = 1 and enq_ready = 0. Hold enq_valid 10 cycles → count stays 4, no enq_done. MIN_FIRST = 0 with the same stimulus → first pop 0x0903.
- Simultaneous: count = 2, enq_valid and deq_req in the same IDLE cycle → enqueue accepted, deq_ready = 0. Dequeue accepted later; count goes 3 then 2.
- Latency: count = 3, accept enqueue at T → enq_done exactly at T+7. Dequeue with count = 4 accepted at T → deq_valid at T+2, deq_ready at T+9.
- Flush: pulse flush during ENQ_CMP with count = 3 → next cycle count = 0, IDLE, no enq_done. Following deq_req is ignored (deq_ready = 0).

Source files
------------

// File: rtl/quickq_pkg.sv
// Shared types and helpers for the QuickQ sorted-queue controller.
//   qq_state_t : controller FSM states
//   precedes() : ordering test between two keys (strict, so equal keys
//                keep insertion order)
package quickq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENQ_READ,
    ENQ_CMP,
    ENQ_WRITE,
    DEQ_READ0,
    DEQ_OUT,
    DEQ_READ,
    DEQ_SHIFT
  } qq_state_t;

  // Callers zero-extend their KEY_W slice to this width.
  localparam int KEY_MAX_W = 64;

  function automatic logic precedes(input logic [KEY_MAX_W-1:0] a,
                                    input logic [KEY_MAX_W-1:0] b,
                                    input logic                 min_first);
    return min_first ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/quickq_ram.sv
// Entry storage for QuickQ: DEPTH x DATA_W, one synchronous read port
// (1-cycle latency) and one write port. A same-address read during a
// write returns the old contents. The array is not reset.
//   clk      : clock
//   rd_en    : read strobe, rd_addr sampled on the clock edge
//   rd_data  : registered read data
//   wr_en    : write strobe for wr_addr / wr_data
module quickq_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/quickq_sorted_ctrl.sv
// QuickQ sorted-queue controller. Keeps up to DEPTH entries ordered by key
// in a 1R1W RAM. Enqueue walks the stored entries doing an insertion sort
// (the held value swaps with every entry it precedes, the final held value
// lands at the tail); dequeue pops the head and shifts the rest down.
//   clk, rst        : clock, asynchronous active-low reset
//   flush           : synchronous clear, abandons any operation in flight
//   enq_valid/ready : enqueue handshake, enq_data is the entry to insert
//   enq_done        : pulse when the insertion has completed
//   deq_req/ready   : dequeue handshake
//   deq_valid       : pulse, deq_data holds the popped head (held after)
//   count/full/empty: occupancy, busy: controller not idle
module quickq_sorted_ctrl
  import quickq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int KEY_W     = 16,
  parameter int DEPTH     = 16,
  parameter int MIN_FIRST = 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              enq_valid,
  input  logic [DATA_W-1:0] enq_data,
  output logic              enq_ready,
  input  logic              deq_req,
  output logic              deq_ready,
  output logic              deq_valid,
  output logic [DATA_W-1:0] deq_data,
  output logic              enq_done,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              busy
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  qq_state_t         state, state_d;
  logic [CNT_W-1:0]  idx, idx_nxt, idx_prv;
  logic [DATA_W-1:0] hold, rd_data, wr_data, data_q;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic              rd_en, wr_en, win, enq_fire, deq_fire;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign enq_ready = (state == IDLE) && !full && !flush;
  assign enq_fire  = enq_valid && enq_ready;
  // enqueue wins a same-cycle race
  assign deq_ready = (state == IDLE) && !empty && !flush && !enq_fire;
  assign deq_fire  = deq_req && deq_ready;
  assign idx_nxt   = idx + ONE;
  assign idx_prv   = idx - ONE;
  assign win       = precedes(KEY_MAX_W'(hold[DATA_W-1 -: KEY_W]),
                              KEY_MAX_W'(rd_data[DATA_W-1 -: KEY_W]),
                              MIN_FIRST != 0);
  // head arrives from the RAM in DEQ_OUT; show it directly that cycle and
  // keep the registered copy afterwards
  assign deq_data  = deq_valid ? rd_data : data_q;

  quickq_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk    (clk),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d   = state;
    rd_en     = 1'b0;
    rd_addr   = idx[AW-1:0];
    wr_en     = 1'b0;
    wr_addr   = idx[AW-1:0];
    wr_data   = hold;
    enq_done  = 1'b0;
    deq_valid = 1'b0;
    case (state)
      IDLE: begin
        if (enq_fire)      state_d = empty ? ENQ_WRITE : ENQ_READ;
        else if (deq_fire) state_d = DEQ_READ0;
      end
      ENQ_READ: begin
        rd_en   = 1'b1;
        state_d = ENQ_CMP;
      end
      ENQ_CMP: begin
        wr_en   = win;
        state_d = (idx_nxt == count) ? ENQ_WRITE : ENQ_READ;
      end
      ENQ_WRITE: begin
        wr_en    = 1'b1;
        enq_done = 1'b1;
        state_d  = IDLE;
      end
      DEQ_READ0: begin
        rd_en   = 1'b1;
        rd_addr = '0;
        state_d = DEQ_OUT;
      end
      DEQ_OUT: begin
        deq_valid = 1'b1;
        state_d   = (count == ONE) ? IDLE : DEQ_READ;
      end
      DEQ_READ: begin
        rd_en   = 1'b1;
        state_d = DEQ_SHIFT;
      end
      DEQ_SHIFT: begin
        wr_en   = 1'b1;
        wr_addr = idx_prv[AW-1:0];
        wr_data = rd_data;
        state_d = (idx_nxt == count) ? IDLE : DEQ_READ;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d   = IDLE;
      wr_en     = 1'b0;
      enq_done  = 1'b0;
      deq_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      idx    <= '0;
      hold   <= '0;
      data_q <= '0;
    end else if (flush) begin
      count <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (enq_fire) begin
          hold <= enq_data;
          idx  <= '0;
        end
        ENQ_CMP: begin
          if (win) hold <= rd_data;
          idx <= idx_nxt;
        end
        ENQ_WRITE: count <= count + ONE;
        DEQ_OUT: begin
          data_q <= rd_data;
          if (count == ONE) count <= '0;
          else              idx   <= ONE;
        end
        DEQ_SHIFT: begin
          idx <= idx_nxt;
          if (idx_nxt == count) count <= count - ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quickq_sorted_ctrl.sv
// Directed bench for quickq_sorted_ctrl. Two instances (smallest-first and
// largest-first) share one stimulus stream; expected pops are queued per
// instance and a monitor compares them whenever deq_valid pulses.
module tb_quickq_sorted_ctrl;
  localparam int DW = 16, KW = 8, DP = 4, CW = $clog2(DP + 1);

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, enq_valid = 1'b0, deq_req = 1'b0;
  logic [DW-1:0] enq_data = '0;
  logic enq_ready, deq_ready, deq_valid, enq_done, full, empty, busy;
  logic enq_ready_b, deq_ready_b, deq_valid_b, enq_done_b, full_b, empty_b, busy_b;
  logic [DW-1:0] deq_data, deq_data_b;
  logic [CW-1:0] count, count_b;

  int checks = 0, failures = 0, cyc = 0, dv_cyc = -1;
  logic [DW-1:0] exp1[$], exp0[$];

  quickq_sorted_ctrl #(.DATA_W(DW), .KEY_W(KW), .DEPTH(DP), .MIN_FIRST(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_data(enq_data),
    .enq_ready(enq_ready), .deq_req(deq_req), .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_data(deq_data), .enq_done(enq_done), .count(count), .full(full), .empty(empty),
    .busy(busy));

  quickq_sorted_ctrl #(.DATA_W(DW), .KEY_W(KW), .DEPTH(DP), .MIN_FIRST(0)) dut_max (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_data(enq_data),
    .enq_ready(enq_ready_b), .deq_req(deq_req), .deq_ready(deq_ready_b), .deq_valid(deq_valid_b),
    .deq_data(deq_data_b), .enq_done(enq_done_b), .count(count_b), .full(full_b), .empty(empty_b),
    .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (deq_valid) begin
      dv_cyc = cyc;
      if (exp1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_pop_min: got %0h expected none", deq_data);
      end else chk("pop_min_first", 32'(deq_data), 32'(exp1.pop_front()));
    end
    if (deq_valid_b) begin
      if (exp0.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_pop_max: got %0h expected none", deq_data_b);
      end else chk("pop_max_first", 32'(deq_data_b), 32'(exp0.pop_front()));
    end
  end

  task automatic do_enq(input logic [DW-1:0] d, output int t_acc, output int t_done);
    int n;
    @(posedge clk); #2; enq_valid = 1'b1; enq_data = d;
    n = 0;
    @(negedge clk);
    while (!enq_ready && n < 50) begin @(negedge clk); n++; end
    t_acc = cyc;
    if (!enq_ready) begin
      checks++; failures++;
      $display("FAIL enq_accept_timeout: got no ready expected ready data=%0h", d);
    end
    @(posedge clk); #2; enq_valid = 1'b0;
    n = 0; t_done = -1;
    while (n < 100) begin
      @(negedge clk);
      if (enq_done) begin t_done = cyc; break; end
      n++;
    end
    if (t_done < 0) begin
      checks++; failures++;
      $display("FAIL enq_done_timeout: got no enq_done expected pulse data=%0h", d);
    end
  endtask

  task automatic do_deq(output int t_acc, output int t_idle);
    int n;
    @(posedge clk); #2; deq_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!deq_ready && n < 50) begin @(negedge clk); n++; end
    t_acc = cyc;
    if (!deq_ready) begin
      checks++; failures++;
      $display("FAIL deq_accept_timeout: got no ready expected ready");
    end
    @(posedge clk); #2; deq_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    t_idle = cyc;
    if (busy) begin
      checks++; failures++;
      $display("FAIL deq_idle_timeout: got busy expected idle");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, td, ti, nbad;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_enq_done", 32'(enq_done), 0);
    chk("rst_deq_valid", 32'(deq_valid), 0);
    chk("rst_deq_data", 32'(deq_data), 0);
    @(posedge clk); #2; rst = 1'b1;

    // reset in the middle of an enqueue with two entries stored
    do_enq(16'h0501, ta, td);
    do_enq(16'h0202, ta, td);
    @(negedge clk); chk("count_pre_reset", 32'(count), 2);
    @(posedge clk); #2; enq_valid = 1'b1; enq_data = 16'h0903;
    @(negedge clk); chk("enq_ready_idle", 32'(enq_ready), 1);
    @(posedge clk); #2; enq_valid = 1'b0;
    @(negedge clk); chk("busy_mid_enq", 32'(busy), 1);
    #1; rst = 1'b0; #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_busy", 32'(busy), 0);
    @(posedge clk); #2; rst = 1'b1;
    @(negedge clk); chk("enq_ready_after_rst", 32'(enq_ready), 1);

    // ordering fill; last insert with 3 stored checks latency
    do_enq(16'h0501, ta, td);
    do_enq(16'h0202, ta, td);
    do_enq(16'h0903, ta, td);
    do_enq(16'h0204, ta, td);
    chk("enq_latency_n3", 32'(td - ta), 7);
    @(negedge clk);
    chk("fill_count", 32'(count), 4);
    chk("fill_full", 32'(full), 1);
    chk("fill_enq_ready", 32'(enq_ready), 0);
    chk("fill_count_max", 32'(count_b), 4);

    // hold enqueue against a full queue
    @(posedge clk); #2; enq_valid = 1'b1; enq_data = 16'h0100;
    nbad = 0;
    repeat (10) begin
      @(negedge clk);
      if (enq_ready || enq_done || count != 3'd4) nbad++;
    end
    enq_valid = 1'b0;
    chk("full_hold_bad_cycles", 32'(nbad), 0);

    // drain: stable order for min-first, reversed keys for max-first
    exp1.push_back(16'h0202); exp0.push_back(16'h0903);
    do_deq(ta, ti);
    chk("deq_valid_latency", 32'(dv_cyc - ta), 2);
    chk("deq_ready_latency", 32'(ti - ta), 9);
    chk("deq_ready_back", 32'(deq_ready), 1);
    chk("count_after_pop", 32'(count), 3);
    exp1.push_back(16'h0204); exp0.push_back(16'h0501);
    do_deq(ta, ti);
    exp1.push_back(16'h0501); exp0.push_back(16'h0202);
    do_deq(ta, ti);
    exp1.push_back(16'h0903); exp0.push_back(16'h0204);
    do_deq(ta, ti);
    chk("held_deq_data", 32'(deq_data), 32'h0903);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_deq_ready", 32'(deq_ready), 0);

    // simultaneous enqueue and dequeue with two stored
    do_enq(16'h0303, ta, td);
    do_enq(16'h0707, ta, td);
    exp1.push_back(16'h0101); exp0.push_back(16'h0707);
    @(posedge clk); #2; enq_valid = 1'b1; enq_data = 16'h0101; deq_req = 1'b1;
    @(negedge clk);
    chk("sim_enq_ready", 32'(enq_ready), 1);
    chk("sim_deq_ready", 32'(deq_ready), 0);
    @(posedge clk); #2; enq_valid = 1'b0;
    nbad = 0;
    @(negedge clk);
    while (!enq_done && nbad < 50) begin @(negedge clk); nbad++; end
    chk("sim_enq_done", 32'(enq_done), 1);
    @(negedge clk);
    chk("sim_count3", 32'(count), 3);
    chk("sim_deq_ready_later", 32'(deq_ready), 1);
    @(posedge clk); #2; deq_req = 1'b0;
    nbad = 0;
    @(negedge clk);
    while (busy && nbad < 50) begin @(negedge clk); nbad++; end
    chk("sim_count2", 32'(count), 2);

    // flush during ENQ_CMP with three stored
    do_enq(16'h0505, ta, td);
    @(negedge clk); chk("pre_flush_count", 32'(count), 3);
    @(posedge clk); #2; enq_valid = 1'b1; enq_data = 16'h0606;
    @(negedge clk); chk("flush_enq_accept", 32'(enq_ready), 1);
    @(posedge clk); #2; enq_valid = 1'b0;
    @(posedge clk); #2; flush = 1'b1;
    @(negedge clk);
    chk("flush_enq_ready", 32'(enq_ready), 0);
    chk("flush_busy_cmp", 32'(busy), 1);
    @(posedge clk); #2; flush = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 0);
    chk("flush_busy", 32'(busy), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_no_done", 32'(enq_done), 0);
    chk("flush_count_max", 32'(count_b), 0);
    @(posedge clk); #2; deq_req = 1'b1;
    nbad = 0;
    repeat (5) begin
      @(negedge clk);
      if (deq_ready || busy || count != 3'd0) nbad++;
    end
    deq_req = 1'b0;
    chk("flush_deq_ignored", 32'(nbad), 0);

    // operation resumes after flush
    exp1.push_back(16'h0a0a); exp0.push_back(16'h0a0a);
    do_enq(16'h0a0a, ta, td);
    chk("post_flush_enq_latency", 32'(td - ta), 1);
    do_deq(ta, ti);
    chk("post_flush_empty", 32'(empty), 1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp1.size() + exp0.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
